// File: rtl/gpu_io_pkg.sv
// Shared types and constants for the GPU UART input path.
// Packet offsets are also consumed by the top level when it loads scene registers.
package gpu_io_pkg;

  localparam int CLK_HZ_DEF = 40_000_000;
  localparam int BAUD_DEF   = 115_200;
  localparam int NUM_BYTES  = 60;
  localparam int IDX_W      = 7;

  localparam int VP_00_OFS       = 30;
  localparam int RENDER_MODE_OFS = 59;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Full bit period, or half of it for the start-bit midpoint (both truncated).
  function automatic int uart_cycles(input int clk_hz, input int baud, input bit half);
    int bit_cyc;
    bit_cyc = clk_hz / baud;
    return half ? (bit_cyc / 2) : bit_cyc;
  endfunction

endpackage

// File: rtl/uart_packet_rx_if.sv
// Byte/strobe bundle between the UART packet receiver and the register loader.
interface uart_packet_rx_if;
  import gpu_io_pkg::*;

  logic             rx;
  logic [7:0]       read_data;
  logic [IDX_W-1:0] idx;
  logic             update_reg;
  logic             pc_ready;
  logic             rx_err;

  modport master (
    input  rx,
    output read_data, idx, update_reg, pc_ready, rx_err
  );

  modport slave (
    output rx,
    input  read_data, idx, update_reg, pc_ready, rx_err
  );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART byte receiver: input synchroniser, start/data/stop FSM, mid-bit sampling.
// byte_valid / frame_err are single-cycle combinational flags raised at the stop-bit sample.
module uart_rx_core
  import gpu_io_pkg::*;
#(
  parameter int BIT_CYC  = 347,
  parameter int HALF_CYC = 173
) (
  input  logic       clk_40,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       in_idle,
  output logic [7:0] byte_data
);

  localparam int CNT_W = $clog2(BIT_CYC + 1);

  logic             sync1_q, sync2_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_s;

  assign rx_s      = sync2_q;
  assign in_idle   = (state_q == IDLE);
  assign byte_data = shift_q;

  always_ff @(posedge clk_40 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Re-check the line at mid start bit; a short low pulse is a glitch.
        if (cnt_q == CNT_W'(HALF_CYC - 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_valid = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A held-low (break) line must not look like a stream of start bits.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_packet_rx.sv
// Scene-packet front end: numbers received bytes 0..NUM_BYTES-1, strobes each one out,
// flags packet completion, and drops framing on stop-bit errors or idle gaps.
module uart_packet_rx
  import gpu_io_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEF,
  parameter int BAUD         = BAUD_DEF,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              clk_40,
  input  logic              rst_n,
  uart_packet_rx_if.master  bus
);

  localparam int BIT_CYC  = uart_cycles(CLK_HZ, BAUD, 1'b0);
  localparam int HALF_CYC = uart_cycles(CLK_HZ, BAUD, 1'b1);
  localparam int TMO_CYC  = TIMEOUT_BITS * BIT_CYC;
  localparam int TMO_W    = $clog2(TMO_CYC + 1);

  logic       byte_valid, frame_err, in_idle;
  logic [7:0] byte_data;

  uart_rx_core #(
    .BIT_CYC  (BIT_CYC),
    .HALF_CYC (HALF_CYC)
  ) u_core (
    .clk_40     (clk_40),
    .rst_n      (rst_n),
    .rx         (bus.rx),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .in_idle    (in_idle),
    .byte_data  (byte_data)
  );

  logic [IDX_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       read_data_q, read_data_d;
  logic             update_q, update_d;
  logic             pc_ready_q, pc_ready_d;
  logic             rx_err_q, rx_err_d;
  logic [TMO_W-1:0] idle_cnt_q, idle_cnt_d;

  always_ff @(posedge clk_40 or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      idx_q       <= '0;
      read_data_q <= '0;
      update_q    <= 1'b0;
      pc_ready_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      idx_q       <= idx_d;
      read_data_q <= read_data_d;
      update_q    <= update_d;
      pc_ready_q  <= pc_ready_d;
      rx_err_q    <= rx_err_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    idx_d       = idx_q;
    read_data_d = read_data_q;
    update_d    = 1'b0;
    rx_err_d    = 1'b0;
    idle_cnt_d  = '0;
    // Trails the last byte's strobe so its register load has settled downstream.
    pc_ready_d  = update_q && (idx_q == IDX_W'(NUM_BYTES - 1));
    if (byte_valid) begin
      read_data_d = byte_data;
      idx_d       = byte_cnt_q;
      update_d    = 1'b1;
      byte_cnt_d  = (byte_cnt_q == IDX_W'(NUM_BYTES - 1)) ? '0 : byte_cnt_q + 1'b1;
    end else if (frame_err) begin
      byte_cnt_d = '0;
      rx_err_d   = 1'b1;
    end else if (in_idle && (byte_cnt_q != '0)) begin
      if (idle_cnt_q == TMO_W'(TMO_CYC - 1)) begin
        byte_cnt_d = '0;
        rx_err_d   = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  assign bus.read_data  = read_data_q;
  assign bus.idx        = idx_q;
  assign bus.update_reg = update_q;
  assign bus.pc_ready   = pc_ready_q;
  assign bus.rx_err     = rx_err_q;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench: a fast-baud instance for packet-level scenarios and a default-rate
// instance for the absolute latency and glitch scenarios.
`timescale 1ns/1ps
module tb_uart_packet_rx;

  localparam int S_BAUD   = 2_500_000;       // 40 MHz / 2.5 MBd = 16 cycles per bit
  localparam int S_BIT_NS = 16 * 25;
  localparam int D_BIT_NS = 347 * 25;

  logic clk_40 = 1'b0;
  logic rst_n_s, rst_n_d;
  always #12.5 clk_40 = ~clk_40;

  uart_packet_rx_if bus_s();
  uart_packet_rx_if bus_d();

  uart_packet_rx #(.CLK_HZ(40_000_000), .BAUD(S_BAUD), .TIMEOUT_BITS(20)) dut_s (
    .clk_40 (clk_40),
    .rst_n  (rst_n_s),
    .bus    (bus_s)
  );

  uart_packet_rx dut_d (
    .clk_40 (clk_40),
    .rst_n  (rst_n_d),
    .bus    (bus_d)
  );

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  longint start_cyc = 0;

  logic [7:0] sd[$];
  logic [6:0] si[$];
  longint     sc[$];
  int         s_pc, s_err;
  longint     s_pc_cyc, s_err_cyc;

  logic [7:0] dd[$];
  logic [6:0] di[$];
  longint     dc[$];
  int         d_pc, d_err;

  always @(posedge clk_40) cyc <= cyc + 1;

  always @(negedge clk_40) begin
    if (bus_s.update_reg === 1'b1) begin
      sd.push_back(bus_s.read_data);
      si.push_back(bus_s.idx);
      sc.push_back(cyc);
      $display("strobe dut=s idx=%0d data=%h cyc=%0d", bus_s.idx, bus_s.read_data, cyc);
      total++;
      if (bus_s.pc_ready !== 1'b0 || bus_s.rx_err !== 1'b0) begin
        bad++;
        $display("FAIL overlap_s pc_ready=%b rx_err=%b want 0 0 with update_reg", bus_s.pc_ready, bus_s.rx_err);
      end
    end
    if (bus_s.pc_ready === 1'b1) begin s_pc++; s_pc_cyc = cyc; end
    if (bus_s.rx_err === 1'b1) begin s_err++; s_err_cyc = cyc; end
    if (bus_d.update_reg === 1'b1) begin
      dd.push_back(bus_d.read_data);
      di.push_back(bus_d.idx);
      dc.push_back(cyc);
      $display("strobe dut=d idx=%0d data=%h cyc=%0d", bus_d.idx, bus_d.read_data, cyc);
    end
    if (bus_d.pc_ready === 1'b1) d_pc++;
    if (bus_d.rx_err === 1'b1) d_err++;
  end

  task automatic clear_s();
    sd.delete(); si.delete(); sc.delete();
    s_pc = 0; s_err = 0; s_pc_cyc = 0; s_err_cyc = 0;
  endtask

  task automatic clear_d();
    dd.delete(); di.delete(); dc.delete();
    d_pc = 0; d_err = 0;
  endtask

  task automatic drive(input bit to_d, input logic v);
    if (to_d) bus_d.rx = v;
    else      bus_s.rx = v;
  endtask

  task automatic send_byte(input bit to_d, input logic [7:0] b, input int bit_ns, input logic stop_bit);
    start_cyc = cyc;
    drive(to_d, 1'b0);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      drive(to_d, b[i]);
      #(bit_ns);
    end
    drive(to_d, stop_bit);
    #(bit_ns);
    drive(to_d, 1'b1);
    if (!stop_bit) #(bit_ns);
  endtask

  task automatic settle_s();
    #(30 * S_BIT_NS);
    clear_s();
  endtask

  task automatic test_reset();
    rst_n_s = 1'b0; rst_n_d = 1'b0;
    bus_s.rx = 1'b1; bus_d.rx = 1'b1;
    #60;
    total += 10;
    if (bus_s.read_data !== 8'h00) begin bad++; $display("FAIL reset_read_data_s got=%h want=00", bus_s.read_data); end
    if (bus_s.idx !== 7'd0) begin bad++; $display("FAIL reset_idx_s got=%0d want=0", bus_s.idx); end
    if (bus_s.update_reg !== 1'b0) begin bad++; $display("FAIL reset_update_s got=%b want=0", bus_s.update_reg); end
    if (bus_s.pc_ready !== 1'b0) begin bad++; $display("FAIL reset_pc_ready_s got=%b want=0", bus_s.pc_ready); end
    if (bus_s.rx_err !== 1'b0) begin bad++; $display("FAIL reset_rx_err_s got=%b want=0", bus_s.rx_err); end
    if (bus_d.read_data !== 8'h00) begin bad++; $display("FAIL reset_read_data_d got=%h want=00", bus_d.read_data); end
    if (bus_d.idx !== 7'd0) begin bad++; $display("FAIL reset_idx_d got=%0d want=0", bus_d.idx); end
    if (bus_d.update_reg !== 1'b0) begin bad++; $display("FAIL reset_update_d got=%b want=0", bus_d.update_reg); end
    if (bus_d.pc_ready !== 1'b0) begin bad++; $display("FAIL reset_pc_ready_d got=%b want=0", bus_d.pc_ready); end
    if (bus_d.rx_err !== 1'b0) begin bad++; $display("FAIL reset_rx_err_d got=%b want=0", bus_d.rx_err); end
    @(negedge clk_40);
    rst_n_s = 1'b1; rst_n_d = 1'b1;
    repeat (4) @(posedge clk_40);
    clear_s(); clear_d();
  endtask

  task automatic test_single_byte();
    longint c0;
    @(posedge clk_40); #1;
    c0 = cyc;
    send_byte(1'b1, 8'hA5, D_BIT_NS, 1'b1);
    #(2 * D_BIT_NS);
    total++;
    if (dd.size() != 1) begin
      bad++; $display("FAIL single_count got=%0d want=1", dd.size());
    end else begin
      total += 3;
      if (dd[0] !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", dd[0]); end
      if (di[0] !== 7'd0) begin bad++; $display("FAIL single_idx got=%0d want=0", di[0]); end
      if (dc[0] - c0 < 3298 || dc[0] - c0 > 3300) begin
        bad++; $display("FAIL single_latency got=%0d want=3299+-1", dc[0] - c0);
      end
    end
    total += 2;
    if (d_pc != 0) begin bad++; $display("FAIL single_pc_ready got=%0d want=0", d_pc); end
    if (d_err != 0) begin bad++; $display("FAIL single_rx_err got=%0d want=0", d_err); end
  endtask

  task automatic test_glitch();
    clear_d();
    drive(1'b1, 1'b0);
    #(100 * 25);
    drive(1'b1, 1'b1);
    #(300 * 25);
    total += 2;
    if (dd.size() != 0) begin bad++; $display("FAIL glitch_strobe got=%0d want=0", dd.size()); end
    if (d_err != 0) begin bad++; $display("FAIL glitch_rx_err got=%0d want=0", d_err); end
    send_byte(1'b1, 8'h3C, D_BIT_NS, 1'b1);
    #(D_BIT_NS);
    total++;
    if (dd.size() != 1) begin
      bad++; $display("FAIL glitch_follow_count got=%0d want=1", dd.size());
    end else begin
      total += 2;
      if (dd[0] !== 8'h3C) begin bad++; $display("FAIL glitch_follow_data got=%h want=3c", dd[0]); end
      if (di[0] !== 7'd1) begin bad++; $display("FAIL glitch_follow_idx got=%0d want=1", di[0]); end
    end
  endtask

  task automatic test_packet();
    longint c0;
    clear_s();
    @(posedge clk_40); #1;
    c0 = cyc;
    for (int i = 0; i < 60; i++) send_byte(1'b0, 8'(i), S_BIT_NS, 1'b1);
    #(2 * S_BIT_NS);
    total++;
    if (sd.size() != 60) begin
      bad++; $display("FAIL packet_count got=%0d want=60", sd.size());
    end else begin
      for (int i = 0; i < 60; i++) begin
        total++;
        if (si[i] !== 7'(i) || sd[i] !== 8'(i)) begin
          bad++; $display("FAIL packet_byte%0d got idx=%0d data=%h want idx=%0d data=%h", i, si[i], sd[i], i, i[7:0]);
        end
      end
      total += 2;
      if (sc[0] - c0 < 154 || sc[0] - c0 > 156) begin
        bad++; $display("FAIL packet_latency got=%0d want=155+-1", sc[0] - c0);
      end
      if (s_pc_cyc != sc[59] + 1) begin
        bad++; $display("FAIL packet_pc_timing got=%0d want=%0d", s_pc_cyc, sc[59] + 1);
      end
    end
    total++;
    if (s_pc != 1) begin bad++; $display("FAIL packet_pc_count got=%0d want=1", s_pc); end
    send_byte(1'b0, 8'h77, S_BIT_NS, 1'b1);
    send_byte(1'b0, 8'h78, S_BIT_NS, 1'b1);
    #(S_BIT_NS);
    total++;
    if (si.size() != 62) begin
      bad++; $display("FAIL packet2_count got=%0d want=62", si.size());
    end else begin
      total += 2;
      if (si[60] !== 7'd0 || sd[60] !== 8'h77) begin bad++; $display("FAIL packet2_first got idx=%0d data=%h want idx=0 data=77", si[60], sd[60]); end
      if (si[61] !== 7'd1 || sd[61] !== 8'h78) begin bad++; $display("FAIL packet2_second got idx=%0d data=%h want idx=1 data=78", si[61], sd[61]); end
    end
    total++;
    if (s_pc != 1) begin bad++; $display("FAIL packet2_pc_count got=%0d want=1", s_pc); end
    settle_s();
  endtask

  task automatic test_frame_err();
    logic [7:0] exp_d [7];
    logic [6:0] exp_i [7];
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h16, 8'h17};
    exp_i = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd0, 7'd1};
    clear_s();
    for (int i = 0; i < 5; i++) send_byte(1'b0, 8'h10 + 8'(i), S_BIT_NS, 1'b1);
    send_byte(1'b0, 8'h15, S_BIT_NS, 1'b0);
    send_byte(1'b0, 8'h16, S_BIT_NS, 1'b1);
    send_byte(1'b0, 8'h17, S_BIT_NS, 1'b1);
    #(S_BIT_NS);
    total += 2;
    if (s_err != 1) begin bad++; $display("FAIL frame_rx_err got=%0d want=1", s_err); end
    if (sd.size() != 7) begin
      bad++; $display("FAIL frame_count got=%0d want=7", sd.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        total++;
        if (si[i] !== exp_i[i] || sd[i] !== exp_d[i]) begin
          bad++; $display("FAIL frame_byte%0d got idx=%0d data=%h want idx=%0d data=%h", i, si[i], sd[i], exp_i[i], exp_d[i]);
        end
      end
    end
    settle_s();
  endtask

  task automatic test_timeout();
    longint t_end;
    clear_s();
    for (int i = 0; i < 10; i++) send_byte(1'b0, 8'hC0 + 8'(i), S_BIT_NS, 1'b1);
    t_end = cyc;
    #(25 * S_BIT_NS);
    send_byte(1'b0, 8'h99, S_BIT_NS, 1'b1);
    #(S_BIT_NS);
    total += 3;
    if (s_err != 1) begin bad++; $display("FAIL timeout_rx_err got=%0d want=1", s_err); end
    if (s_err_cyc - t_end < 300 || s_err_cyc - t_end > 330) begin
      bad++; $display("FAIL timeout_mark got=%0d cycles want=300..330", s_err_cyc - t_end);
    end
    if (sd.size() != 11) begin
      bad++; $display("FAIL timeout_count got=%0d want=11", sd.size());
    end else begin
      total += 2;
      if (si[9] !== 7'd9 || sd[9] !== 8'hC9) begin bad++; $display("FAIL timeout_last got idx=%0d data=%h want idx=9 data=c9", si[9], sd[9]); end
      if (si[10] !== 7'd0 || sd[10] !== 8'h99) begin bad++; $display("FAIL timeout_next got idx=%0d data=%h want idx=0 data=99", si[10], sd[10]); end
    end
    settle_s();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h5A;
    clear_s();
    for (int i = 0; i < 30; i++) send_byte(1'b0, 8'(i), S_BIT_NS, 1'b1);
    drive(1'b0, 1'b0);
    #(S_BIT_NS);
    for (int i = 0; i < 4; i++) begin drive(1'b0, b[i]); #(S_BIT_NS); end
    drive(1'b0, b[4]);
    #(S_BIT_NS / 2);
    rst_n_s = 1'b0;
    #1;
    total += 5;
    if (bus_s.read_data !== 8'h00) begin bad++; $display("FAIL midrst_read_data got=%h want=00", bus_s.read_data); end
    if (bus_s.idx !== 7'd0) begin bad++; $display("FAIL midrst_idx got=%0d want=0", bus_s.idx); end
    if (bus_s.update_reg !== 1'b0) begin bad++; $display("FAIL midrst_update got=%b want=0", bus_s.update_reg); end
    if (bus_s.pc_ready !== 1'b0) begin bad++; $display("FAIL midrst_pc_ready got=%b want=0", bus_s.pc_ready); end
    if (bus_s.rx_err !== 1'b0) begin bad++; $display("FAIL midrst_rx_err got=%b want=0", bus_s.rx_err); end
    drive(1'b0, 1'b1);
    #(2 * S_BIT_NS);
    rst_n_s = 1'b1;
    #(2 * S_BIT_NS);
    clear_s();
    send_byte(1'b0, 8'h66, S_BIT_NS, 1'b1);
    #(S_BIT_NS);
    total++;
    if (sd.size() != 1) begin
      bad++; $display("FAIL midrst_count got=%0d want=1", sd.size());
    end else begin
      total++;
      if (si[0] !== 7'd0 || sd[0] !== 8'h66) begin bad++; $display("FAIL midrst_next got idx=%0d data=%h want idx=0 data=66", si[0], sd[0]); end
    end
    settle_s();
  endtask

  task automatic test_baud_skew(input int bit_ns);
    clear_s();
    for (int i = 0; i < 60; i++) send_byte(1'b0, 8'(i * 7 + 3), bit_ns, 1'b1);
    #(2 * bit_ns);
    total += 3;
    if (s_pc != 1) begin bad++; $display("FAIL skew%0d_pc_count got=%0d want=1", bit_ns, s_pc); end
    if (s_err != 0) begin bad++; $display("FAIL skew%0d_rx_err got=%0d want=0", bit_ns, s_err); end
    if (sd.size() != 60) begin
      bad++; $display("FAIL skew%0d_count got=%0d want=60", bit_ns, sd.size());
    end else begin
      for (int i = 0; i < 60; i++) begin
        total++;
        if (si[i] !== 7'(i) || sd[i] !== 8'(i * 7 + 3)) begin
          bad++; $display("FAIL skew%0d_byte%0d got idx=%0d data=%h want idx=%0d data=%h", bit_ns, i, si[i], sd[i], i, 8'(i * 7 + 3));
        end
      end
    end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_packet();
    test_frame_err();
    test_timeout();
    test_reset_mid();
    test_baud_skew(408);
    test_baud_skew(392);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
